// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Lines are 4 words (128 bits). Load and store hits complete in one cycle; misses stall the pipeline.
module dcache_ctrl #(
    parameter int NUM_LINES = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          cpu_req_i,
    input  logic          cpu_write_i,
    input  logic [31:0]   cpu_addr_i,
    input  logic [31:0]   cpu_wdata_i,
    output logic [31:0]   cpu_rdata_o,
    output logic          stall_o,
    output logic          mem_enable_o,
    output logic          mem_write_o,
    output logic [31:0]   mem_addr_o,
    output logic [127:0]  mem_data_o,
    input  logic [127:0]  mem_data_i,
    input  logic          mem_ack_i
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [NUM_LINES-1:0] valid, dirty;
    logic [23:0]          tag_mem  [NUM_LINES];
    logic [127:0]         data_mem [NUM_LINES];

    // The missing line is captured at the miss so the transfer stays put even if the CPU drops its request.
    logic [23:0] miss_tag;
    logic [3:0]  miss_index;

    logic [23:0] req_tag;
    logic [3:0]  req_index;
    logic [6:0]  word_lsb;
    logic        hit, miss;
    logic        unused_addr_bits;

    assign req_tag          = cpu_addr_i[31:8];
    assign req_index        = cpu_addr_i[7:4];
    assign word_lsb         = {cpu_addr_i[3:2], 5'd0};
    assign unused_addr_bits = ^cpu_addr_i[1:0];

    assign hit  = (state == IDLE) && cpu_req_i && valid[req_index]
                  && (tag_mem[req_index] == req_tag);
    assign miss = (state == IDLE) && cpu_req_i && !hit;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            valid      <= '0;
            dirty      <= '0;
            miss_tag   <= '0;
            miss_index <= '0;
        end else begin
            state <= state_next;
            if (miss) begin
                miss_tag   <= req_tag;
                miss_index <= req_index;
            end
            if (hit && cpu_write_i) begin
                dirty[req_index] <= 1'b1;
            end
            if (state == ALLOCATE && mem_ack_i) begin
                valid[miss_index] <= 1'b1;
                dirty[miss_index] <= 1'b0;
            end
        end
    end

    // NOTE: tag and data arrays carry no reset; the cleared valid bits already make their contents unreachable.
    always_ff @(posedge clk_i) begin
        if (state == ALLOCATE && mem_ack_i) begin
            tag_mem[miss_index]  <= miss_tag;
            data_mem[miss_index] <= mem_data_i;
        end else if (hit && cpu_write_i) begin
            data_mem[req_index][word_lsb +: 32] <= cpu_wdata_i;
        end
    end

    // NOTE: every output gets its default before the case, so no path through this block infers a latch.
    always_comb begin
        state_next   = state;
        stall_o      = 1'b0;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        cpu_rdata_o  = '0;
        if (!rst_i) begin
            case (state)
                IDLE: begin
                    if (hit && !cpu_write_i) begin
                        cpu_rdata_o = data_mem[req_index][word_lsb +: 32];
                    end
                    if (miss) begin
                        stall_o    = 1'b1;
                        state_next = (valid[req_index] && dirty[req_index]) ? WRITEBACK : ALLOCATE;
                    end
                end
                WRITEBACK: begin
                    stall_o      = 1'b1;
                    mem_enable_o = 1'b1;
                    mem_write_o  = 1'b1;
                    mem_addr_o   = {tag_mem[miss_index], miss_index, 4'h0};
                    mem_data_o   = data_mem[miss_index];
                    if (mem_ack_i) state_next = ALLOCATE;
                end
                ALLOCATE: begin
                    stall_o      = 1'b1;
                    mem_enable_o = 1'b1;
                    mem_addr_o   = {miss_tag, miss_index, 4'h0};
                    if (mem_ack_i) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: cold fill, store hit, write-back eviction, store miss, stray ack, reset mid-fill.
// A small memory responder acks every memory request in its third cycle and logs what it saw.
module tb_dcache_ctrl;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          cpu_req_i, cpu_write_i;
    logic [31:0]   cpu_addr_i, cpu_wdata_i;
    logic [31:0]   cpu_rdata_o;
    logic          stall_o, mem_enable_o, mem_write_o;
    logic [31:0]   mem_addr_o;
    logic [127:0]  mem_data_o;
    logic [127:0]  mem_data_i;
    logic          mem_ack_i;

    dcache_ctrl #(.NUM_LINES(16)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .cpu_req_i    (cpu_req_i),
        .cpu_write_i  (cpu_write_i),
        .cpu_addr_i   (cpu_addr_i),
        .cpu_wdata_i  (cpu_wdata_i),
        .cpu_rdata_o  (cpu_rdata_o),
        .stall_o      (stall_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_data_i   (mem_data_i),
        .mem_ack_i    (mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    logic [127:0] fill_data;
    int           nreq, unstable, stray_data;
    logic         rec_write [2];
    logic [31:0]  rec_addr  [2];
    logic [127:0] rec_data  [2];

    int          stalls;
    logic [31:0] rdata;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at a later falling edge with the request dropped.
    task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          output int n_stall, output logic [31:0] data_out);
        int cnt;
        cnt        = 0;
        n_stall    = 0;
        nreq       = 0;
        unstable   = 0;
        stray_data = 0;
        cpu_req_i   = 1'b1;
        cpu_write_i = wr;
        cpu_addr_i  = addr;
        cpu_wdata_i = wdata;
        #1;
        for (int i = 0; i < 50 && stall_o; i++) begin
            n_stall++;
            if (mem_enable_o) begin
                if (cnt == 0) begin
                    if (nreq < 2) begin
                        rec_write[nreq] = mem_write_o;
                        rec_addr[nreq]  = mem_addr_o;
                        rec_data[nreq]  = mem_data_o;
                    end
                    nreq++;
                end else if (nreq <= 2) begin
                    if (mem_write_o !== rec_write[nreq-1] || mem_addr_o !== rec_addr[nreq-1]
                        || mem_data_o !== rec_data[nreq-1]) unstable++;
                end
                if (!mem_write_o && mem_data_o !== '0) stray_data++;
                cnt++;
                if (cnt == 3) begin
                    mem_ack_i  = 1'b1;
                    mem_data_i = mem_write_o ? '0 : fill_data;
                    cnt        = 0;
                end
            end
            @(negedge clk_i);
            mem_ack_i = 1'b0;
            #1;
        end
        check("stall_released", {127'd0, stall_o}, 128'd0);
        data_out = cpu_rdata_o;
        @(negedge clk_i);
        cpu_req_i = 1'b0;
    endtask

    initial begin
        rst_i       = 1'b1;
        cpu_req_i   = 1'b1;
        cpu_write_i = 1'b0;
        cpu_addr_i  = 32'h0000_0104;
        cpu_wdata_i = '0;
        mem_data_i  = '0;
        mem_ack_i   = 1'b0;
        fill_data   = '0;

        // Reset with a request pending: every output must be quiet.
        repeat (2) @(negedge clk_i);
        #1;
        check("rst_stall",  {127'd0, stall_o},      128'd0);
        check("rst_mem_en", {127'd0, mem_enable_o}, 128'd0);
        check("rst_mem_wr", {127'd0, mem_write_o},  128'd0);
        check("rst_addr",   {96'd0, mem_addr_o},    128'd0);
        check("rst_mdata",  mem_data_o,             128'd0);
        check("rst_rdata",  {96'd0, cpu_rdata_o},   128'd0);
        @(negedge clk_i);
        rst_i     = 1'b0;
        cpu_req_i = 1'b0;

        // Cold load: one fill of line 0x100, word 1 returned.
        fill_data = 128'hDDDDCCCC_BBBBAAAA_99998888_77776666;
        access(1'b0, 32'h0000_0104, '0, stalls, rdata);
        check("cold_stalls", stalls, 4);
        check("cold_nreq",   nreq,   1);
        check("cold_wr",     {127'd0, rec_write[0]}, 128'd0);
        check("cold_addr",   {96'd0, rec_addr[0]},   128'h100);
        check("cold_rdata",  {96'd0, rdata},         128'h9999_8888);
        check("cold_stable", unstable,   0);
        check("cold_mdata0", stray_data, 0);

        // Store hit, then load of the same word.
        access(1'b1, 32'h0000_0108, 32'h1234_5678, stalls, rdata);
        check("st_hit_stalls", stalls, 0);
        check("st_hit_nreq",   nreq,   0);
        access(1'b0, 32'h0000_0108, '0, stalls, rdata);
        check("ld_hit_stalls", stalls, 0);
        check("ld_hit_rdata",  {96'd0, rdata}, 128'h1234_5678);

        // Conflict miss on dirty line 0: write-back then fill.
        fill_data = 128'h0F0F0F03_0F0F0F02_0F0F0F01_0F0F0F00;
        access(1'b0, 32'h0000_1100, '0, stalls, rdata);
        check("evict_stalls", stalls, 7);
        check("evict_nreq",   nreq,   2);
        check("wb_wr",        {127'd0, rec_write[0]}, 128'd1);
        check("wb_addr",      {96'd0, rec_addr[0]},   128'h100);
        check("wb_data",      rec_data[0], 128'hDDDDCCCC_12345678_99998888_77776666);
        check("alloc_wr",     {127'd0, rec_write[1]}, 128'd0);
        check("alloc_addr",   {96'd0, rec_addr[1]},   128'h1100);
        check("evict_rdata",  {96'd0, rdata},         128'h0F0F_0F00);
        check("evict_stable", unstable,   0);
        check("evict_mdata0", stray_data, 0);

        // Store miss to clean index 5: fill only, then the word is written.
        fill_data = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
        access(1'b1, 32'h0000_0054, 32'hCAFE_F00D, stalls, rdata);
        check("stm_stalls", stalls, 4);
        check("stm_nreq",   nreq,   1);
        check("stm_wr",     {127'd0, rec_write[0]}, 128'd0);
        check("stm_addr",   {96'd0, rec_addr[0]},   128'h50);
        access(1'b0, 32'h0000_0054, '0, stalls, rdata);
        check("stm_ld_stalls", stalls, 0);
        check("stm_ld_rdata",  {96'd0, rdata}, 128'hCAFE_F00D);

        // Evicting index 5 proves the store miss left the line dirty.
        fill_data = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;
        access(1'b0, 32'h0000_1058, '0, stalls, rdata);
        check("ev5_stalls", stalls, 7);
        check("ev5_nreq",   nreq,   2);
        check("ev5_wb_wr",  {127'd0, rec_write[0]}, 128'd1);
        check("ev5_wb_addr", {96'd0, rec_addr[0]},  128'h50);
        check("ev5_wb_data", rec_data[0], 128'hA3A3A3A3_A2A2A2A2_CAFEF00D_A0A0A0A0);
        check("ev5_al_addr", {96'd0, rec_addr[1]},  128'h1050);
        check("ev5_rdata",   {96'd0, rdata},        128'hB2B2_B2B2);

        // Stray ack in IDLE must change nothing.
        mem_ack_i  = 1'b1;
        mem_data_i = '1;
        #1;
        check("spur_mem_en", {127'd0, mem_enable_o}, 128'd0);
        check("spur_stall",  {127'd0, stall_o},      128'd0);
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        #1;
        check("spur_after_en",   {127'd0, mem_enable_o}, 128'd0);
        check("spur_after_addr", {96'd0, mem_addr_o},    128'd0);
        @(negedge clk_i);
        access(1'b0, 32'h0000_1058, '0, stalls, rdata);
        check("spur_hit_stalls", stalls, 0);
        check("spur_hit_rdata",  {96'd0, rdata}, 128'hB2B2_B2B2);

        // Reset two cycles into a fill aborts it; the same load then misses again.
        cpu_req_i   = 1'b1;
        cpu_write_i = 1'b0;
        cpu_addr_i  = 32'h0000_2204;
        #1;
        check("abort_miss_stall", {127'd0, stall_o}, 128'd1);
        @(negedge clk_i);
        #1;
        check("abort_alloc_en",   {127'd0, mem_enable_o}, 128'd1);
        check("abort_alloc_addr", {96'd0, mem_addr_o},    128'h2200);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check("abort_mem_en", {127'd0, mem_enable_o}, 128'd0);
        check("abort_stall",  {127'd0, stall_o},      128'd0);
        check("abort_addr",   {96'd0, mem_addr_o},    128'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        fill_data = 128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0;
        access(1'b0, 32'h0000_2204, '0, stalls, rdata);
        check("rerun_stalls", stalls, 4);
        check("rerun_nreq",   nreq,   1);
        check("rerun_addr",   {96'd0, rec_addr[0]}, 128'h2200);
        check("rerun_rdata",  {96'd0, rdata},       128'hC1C1_C1C1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
